// File: rtl/rst_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM encoding, default timing
// constants and a small width helper.
package rst_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  localparam int DEF_NCH           = 4;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_ASSERT_CYCLES = 16;
  localparam int DEF_STAGE_CYCLES  = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sequencer_sync.sv
// Reset-deassertion synchronizer: a chain of flops with D tied high,
// cleared asynchronously by the incoming reset.
module rst_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_sync,
  output logic o_sync_nxt
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_chain <= '0;
    else          r_chain <= {r_chain[STAGES-2:0], 1'b1};
  end

  // o_sync_nxt is the value the output takes on the coming edge, letting the
  // FSM leave SYNC on the same edge the synchronizer output first reads 1.
  assign o_sync     = r_chain[STAGES-1];
  assign o_sync_nxt = r_chain[STAGES-2];

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset sequencer: synchronized deassertion, a fixed all-channel hold,
// then one release slot per channel, with software re-sequencing.
module rst_sequencer
  import rst_sequencer_pkg::*;
#(
  parameter int NCH           = DEF_NCH,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int ASSERT_CYCLES = DEF_ASSERT_CYCLES,
  parameter int STAGE_CYCLES  = DEF_STAGE_CYCLES
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       SwRstReq,
  input  logic [NCH-1:0]             ChanEn,
  output logic [NCH-1:0]             RstOut,
  output logic                       Ready,
  output logic [$clog2(NCH+1)-1:0]   Stage
);

  localparam int SW = $clog2(NCH+1);
  localparam int CW = $clog2(max2(ASSERT_CYCLES, STAGE_CYCLES) + 1);

  state_e          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [NCH-1:0]  r_rel, w_rel_nxt;
  logic [SW-1:0]   w_stage_nxt;
  logic            w_sync, w_sync_nxt;

  rst_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk      (Clk),
    .i_rst_n    (Rst),
    .o_sync     (w_sync),
    .o_sync_nxt (w_sync_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rel_nxt   = r_rel;
    w_stage_nxt = Stage;
    case (r_state)
      ST_SYNC: begin
        if (w_sync || w_sync_nxt) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
          w_rel_nxt   = '0;
          w_stage_nxt = '0;
        end
      end
      ST_HOLD: begin
        if (r_cnt == CW'(ASSERT_CYCLES - 1)) begin
          w_state_nxt  = ST_RELEASE;
          w_cnt_nxt    = '0;
          w_stage_nxt  = '0;
          w_rel_nxt[0] = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_RELEASE: begin
        if (r_cnt == CW'(STAGE_CYCLES - 1)) begin
          w_cnt_nxt = '0;
          if (Stage == SW'(NCH - 1)) begin
            w_state_nxt = ST_RUN;
            w_stage_nxt = SW'(NCH);
          end else begin
            w_stage_nxt = Stage + SW'(1);
            // Flag is set on slot entry, so RstOut drops at the slot's first edge.
            for (int k = 0; k < NCH; k++)
              if (SW'(k) == Stage + SW'(1)) w_rel_nxt[k] = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_RUN: begin
        if (r_cnt != {CW{1'b1}}) w_cnt_nxt = r_cnt + CW'(1);
      end
      default: w_state_nxt = ST_SYNC;
    endcase
    if (SwRstReq && (r_state != ST_SYNC)) begin
      w_state_nxt = ST_HOLD;
      w_cnt_nxt   = '0;
      w_rel_nxt   = '0;
      w_stage_nxt = '0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= ST_SYNC;
      r_cnt   <= '0;
      r_rel   <= '0;
      Stage   <= '0;
      RstOut  <= '1;
      Ready   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rel   <= w_rel_nxt;
      Stage   <= w_stage_nxt;
      RstOut  <= ~(w_rel_nxt & ChanEn);
      Ready   <= (w_state_nxt == ST_RUN);
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Randomized bench for rst_sequencer: two configurations checked every cycle
// against a timeline model (edges since HOLD entry -> expected outputs).
`timescale 1ns/1ps
module tb_rst_sequencer;

  localparam int N_A = 4, SS_A = 2, A_A = 16, S_A = 8;
  localparam int N_B = 1, SS_B = 3, A_B = 1,  S_B = 1;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       SwRstReq = 1'b0;
  logic [3:0] en_a = 4'hF;
  logic [0:0] en_b = 1'b1;
  logic [3:0] rst_a;
  logic [0:0] rst_b;
  logic       rdy_a, rdy_b;
  logic [2:0] stg_a;
  logic [0:0] stg_b;

  int n_cmp = 0, n_bad = 0;

  // model state: in SYNC?, sync edges seen, edges since HOLD entry, sampled enables
  bit   ins_a = 1, ins_b = 1;
  int   sc_a = 0, sc_b = 0, t_a = 0, t_b = 0;
  logic [3:0] smp_a = 4'hF;
  logic [0:0] smp_b = 1'b1;

  rst_sequencer u_a (
    .Clk(Clk), .Rst(Rst), .SwRstReq(SwRstReq), .ChanEn(en_a),
    .RstOut(rst_a), .Ready(rdy_a), .Stage(stg_a)
  );

  rst_sequencer #(.NCH(N_B), .SYNC_STAGES(SS_B), .ASSERT_CYCLES(A_B), .STAGE_CYCLES(S_B)) u_b (
    .Clk(Clk), .Rst(Rst), .SwRstReq(SwRstReq), .ChanEn(en_b),
    .RstOut(rst_b), .Ready(rdy_b), .Stage(stg_b)
  );

  always #50 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, act, exp);
    end
  endtask

  // Channel k is released once t reaches A + k*S; Ready once all N slots elapsed.
  function automatic logic [31:0] e_rst(bit ins, int t, logic [31:0] en, int n, int a, int s);
    logic [31:0] r = '0;
    for (int k = 0; k < n; k++) r[k] = !((!ins && t >= a + k*s) && en[k]);
    return r;
  endfunction

  function automatic logic [31:0] e_rdy(bit ins, int t, int n, int a, int s);
    return (!ins && t >= a + n*s) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] e_stg(bit ins, int t, int n, int a, int s);
    if (ins || t < a)      return 32'd0;
    if (t >= a + n*s)      return 32'(n);
    return 32'((t - a) / s);
  endfunction

  task automatic check_all();
    chk("a_rstout", 32'(rst_a), e_rst(ins_a, t_a, 32'(smp_a), N_A, A_A, S_A));
    chk("a_ready",  32'(rdy_a), e_rdy(ins_a, t_a, N_A, A_A, S_A));
    chk("a_stage",  32'(stg_a), e_stg(ins_a, t_a, N_A, A_A, S_A));
    chk("b_rstout", 32'(rst_b), e_rst(ins_b, t_b, 32'(smp_b), N_B, A_B, S_B));
    chk("b_ready",  32'(rdy_b), e_rdy(ins_b, t_b, N_B, A_B, S_B));
    chk("b_stage",  32'(stg_b), e_stg(ins_b, t_b, N_B, A_B, S_B));
  endtask

  task automatic model_reset();
    ins_a = 1; sc_a = 0; t_a = 0;
    ins_b = 1; sc_b = 0; t_b = 0;
  endtask

  task automatic model_edge(input bit sw);
    if (!Rst) begin
      model_reset();
      return;
    end
    if (ins_a) begin
      sc_a++;
      if (sc_a == SS_A) begin ins_a = 0; t_a = 0; end
    end else t_a = sw ? 0 : t_a + 1;
    if (ins_b) begin
      sc_b++;
      if (sc_b == SS_B) begin ins_b = 0; t_b = 0; end
    end else t_b = sw ? 0 : t_b + 1;
  endtask

  // One clock: check on the falling edge, drive, step the model on the rising
  // edge, optionally pulse Rst low for 30 ns between edges.
  task automatic cyc(input bit sw, input logic [3:0] ea, input logic eb, input bit pulse);
    @(negedge Clk);
    check_all();
    SwRstReq = sw;
    en_a = ea;
    en_b = eb;
    @(posedge Clk);
    #1;
    smp_a = ea;
    smp_b = eb;
    model_edge(sw);
    if (pulse) begin
      #9 Rst = 1'b0;
      #5 model_reset();
      check_all();
      #25 Rst = 1'b1;
    end
  endtask

  initial begin
    #5 Rst = 1'b0;
    #10 check_all();
    repeat (3) cyc(0, 4'hF, 1'b1, 0);
    #5 Rst = 1'b1;

    // clean power-up sequence, all channels enabled
    repeat (60) cyc(0, 4'hF, 1'b1, 0);
    // ChanEn toggles in RUN
    repeat (20) cyc(0, 4'($urandom), 1'($urandom), 0);
    // one-cycle software reset in RUN, channel 2 disabled
    cyc(1, 4'b1011, 1'b1, 0);
    repeat (55) cyc(0, 4'b1011, 1'b1, 0);
    cyc(0, 4'hF, 1'b1, 0);
    // software reset held for 5 cycles
    repeat (5) cyc(1, 4'b1011, 1'b0, 0);
    repeat (55) cyc(0, 4'b1011, 1'b1, 0);
    // async pulse during slot 2 of the release sequence
    cyc(1, 4'hF, 1'b1, 0);
    for (int i = 0; i < 200 && t_a != A_A + 2*S_A + 3; i++) cyc(0, 4'hF, 1'b1, 0);
    cyc(0, 4'hF, 1'b1, 1);
    repeat (60) cyc(0, 4'hF, 1'b1, 0);

    // random mix of enables, software resets and short async pulses
    for (int i = 0; i < 600; i++) begin
      logic [3:0] ea;
      ea = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      cyc($urandom_range(0, 39) == 0, ea, 1'($urandom_range(0, 3) != 0),
          $urandom_range(0, 149) == 0);
    end

    @(negedge Clk);
    check_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 Parameter NCH, default 4: number of sequenced reset channels; legal range 1..16.
REQ-002 Parameter SYNC_STAGES, default 2: depth of the reset-deassertion synchronizer; minimum 2.
REQ-003 Parameter ASSERT_CYCLES, default 16: minimum all-channel assertion time in Clk cycles; minimum 1.
REQ-004 Parameter STAGE_CYCLES, default 8: spacing between successive channel releases; minimum 1.
REQ-005 Clk  input  1  sole clock; all state changes occur on its rising edge.
REQ-006 Rst  input  1  reset, asynchronous and active-low; assertion is immediate, deassertion is synchronized internally.
REQ-007 SwRstReq  input  1  synchronous software reset request, sampled high on a Clk edge.
REQ-008 ChanEn  input  NCH  per-channel enable; 0 holds that channel in reset.
REQ-009 RstOut  output  NCH  per-channel reset, active-high, registered.
REQ-010 Ready  output  1  high when every channel slot has been sequenced (state RUN), registered.
REQ-011 Stage  output  $clog2(NCH+1)  index of the next channel slot to release; equals NCH in RUN.

Function
REQ-012 The FSM SHALL have states SYNC, HOLD, RELEASE and RUN.
REQ-013 SYNC: RstOut all ones, Ready 0; exit to HOLD on the edge where the synchronizer output first reads 1, which is the SYNC_STAGES-th rising edge after Rst deasserts.
REQ-014 HOLD: RstOut all ones; cycle counter runs for exactly ASSERT_CYCLES cycles, then the FSM moves to RELEASE with Stage=0.
REQ-015 RELEASE: one slot per channel, STAGE_CYCLES long; the released flag of channel k is set on the edge ASSERT_CYCLES + k*STAGE_CYCLES after HOLD entry.
REQ-016 Disabled channels still consume their slot; timing is independent of ChanEn.
REQ-017 RUN is entered and Ready rises STAGE_CYCLES after the last slot, i.e. on edge ASSERT_CYCLES + NCH*STAGE_CYCLES after HOLD entry.
REQ-018 RstOut[k] SHALL equal NOT(released[k] AND ChanEn[k]), registered with one cycle latency from ChanEn.
REQ-019 ChanEn[k] falling in any state asserts RstOut[k] on the next edge; ChanEn[k] rising re-releases RstOut[k] on the next edge only if released[k] is set.
REQ-020 SwRstReq high in HOLD, RELEASE or RUN: next edge enters HOLD, clears all released flags, restarts the counter, drives RstOut all ones and Ready 0.
REQ-021 SwRstReq held high SHALL keep the FSM in HOLD, restarting the counter each cycle; the ASSERT_CYCLES count starts after its last high sample.
REQ-022 SwRstReq is ignored in SYNC.
REQ-023 Counter width is $clog2(max(ASSERT_CYCLES, STAGE_CYCLES)+1); the counter never wraps and saturates in RUN.

Reset
REQ-024 Rst low SHALL, without waiting for a Clk edge, force state SYNC, RstOut all ones, Ready 0, Stage 0, counter 0, released flags 0 and synchronizer flops 0.
REQ-025 Rst asserted mid-RELEASE or mid-RUN SHALL abort the sequence; re-sequencing starts from SYNC.
REQ-026 A Rst pulse shorter than one Clk period SHALL still produce the full SYNC/HOLD/RELEASE sequence.

Structure
REQ-027 The state encoding and default parameter constants SHALL live in the shared processor definitions package/include.
REQ-028 The SYNC_STAGES flop chain SHALL be a separate sub-module, rst_sync: async clear, D tied high.
REQ-029 The FSM, counter and released flags SHALL stay in rst_sequencer; there are no other sub-modules.

Verification
REQ-030 Defaults, ChanEn=4'hF, Rst released -> RstOut 4'hF until HOLD-entry+16; then bits clear at +16/+24/+32/+40; Ready=1 at +48; Stage=4.
REQ-031 ChanEn=4'b1011 at power-up -> RstOut[2] stays 1; bits 0, 1 and 3 release at +16, +24 and +40; Ready at +48; setting ChanEn[2]=1 in RUN -> RstOut[2]=0 on the next edge.
REQ-032 One-cycle SwRstReq pulse in RUN -> next edge: RstOut=4'hF, Ready=0; re-release at +16..+40 after the pulse edge; Ready at +48.
REQ-033 SwRstReq held for 5 cycles in HOLD -> first release occurs 16 cycles after the last high sample.
REQ-034 Rst pulsed low for 30 ns between edges during RELEASE (Stage=2) -> RstOut=4'hF immediately, asynchronously; full sequence repeats with identical timing.
REQ-035 NCH=1, ASSERT_CYCLES=1, STAGE_CYCLES=1 -> RstOut[0] falls 1 edge after HOLD entry and Ready rises 2 edges after HOLD entry.
